// File: rtl/adt_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : adt_spi_slave
// Brief    : SPI mode-3 responder emulating the ADT7310 register interface
//            for channel self-test loopback. Optional ADT_SPI_RESET_EN adds
//            the 32-ones serial interface reset.
// Revision : 1.0 - initial release
// ============================================================================
module adt_spi_slave #(
    parameter logic [7:0]  ID_VALUE  = 8'hC3,
    parameter logic [7:0]  CFG_RST   = 8'h00,
    parameter logic [15:0] TCRIT_RST = 16'h4980,
    parameter logic [7:0]  THYST_RST = 8'h05,
    parameter logic [15:0] THIGH_RST = 16'h2000,
    parameter logic [15:0] TLOW_RST  = 16'h0500
) (
    input  logic        clk_sys,
    input  logic        rst_sys,
    input  logic        spi_cs_n,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    input  logic [15:0] temp_value,
    input  logic        temp_load,
    output logic [7:0]  cfg_reg,
    output logic        reg_wr,
    output logic [2:0]  reg_wr_addr,
    output logic        busy,
    output logic        frame_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_RX   = 3'd2;
    localparam logic [2:0] S_TX   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [1:0]  r_cs_pipe;
    logic [1:0]  r_sclk_pipe;
    logic [1:0]  r_mosi_pipe;
    logic        r_sclk_prev;

    logic [2:0]  r_state;
    logic        r_armed;
    logic [3:0]  r_bit_cnt;
    logic [15:0] r_shift;
    logic [2:0]  r_addr;
    logic        r_cont;
    logic        r_wide;
    logic        r_word_seen;

    logic        r_miso;
    logic        r_miso_oe;
    logic        r_reg_wr;
    logic [2:0]  r_reg_wr_addr;
    logic        r_busy;
    logic        r_frame_err;

    logic        r_rdy_n;
    logic [7:0]  r_cfg;
    logic [15:0] r_temp;
    logic [15:0] r_tcrit;
    logic [7:0]  r_thyst;
    logic [15:0] r_thigh;
    logic [15:0] r_tlow;
`ifdef ADT_SPI_RESET_EN
    logic [4:0]  r_ones;
`endif

    logic        w_cs_sync;
    logic        w_sclk_sync;
    logic        w_mosi;
    logic        w_rise;
    logic        w_fall;
    logic [2:0]  w_cmd_addr;
    logic        w_cmd_wide;
    logic [15:0] w_rd_data;
    logic [15:0] w_rx_word;
    logic [3:0]  w_last;
    logic        w_addr_ro;
    logic        w_cont_boundary;

    assign w_cs_sync   = r_cs_pipe[1];
    assign w_sclk_sync = r_sclk_pipe[1];
    assign w_mosi      = r_mosi_pipe[1];
    assign w_rise      = w_sclk_sync & ~r_sclk_prev;
    assign w_fall      = ~w_sclk_sync & r_sclk_prev;

    // The command byte completes with the current MOSI sample, so its fields
    // sit one position lower in the shift register than in the byte itself.
    assign w_cmd_addr  = r_shift[4:2];
    assign w_cmd_wide  = (w_cmd_addr == 3'd2) | (w_cmd_addr == 3'd4) |
                         (w_cmd_addr == 3'd6) | (w_cmd_addr == 3'd7);
    assign w_rx_word   = {r_shift[14:0], w_mosi};
    assign w_last      = r_wide ? 4'd15 : 4'd7;
    assign w_addr_ro   = (r_addr == 3'd0) | (r_addr == 3'd2) | (r_addr == 3'd3);
    assign w_cont_boundary = r_cont && (r_addr == 3'd2) && r_word_seen &&
                             (r_bit_cnt == 4'd0);

    always_comb begin
        w_rd_data = 16'h0000;
        case (w_cmd_addr)
            3'd0:    w_rd_data = {r_rdy_n, 7'b0, 8'h00};
            3'd1:    w_rd_data = {r_cfg, 8'h00};
            3'd2:    w_rd_data = r_temp;
            3'd3:    w_rd_data = {ID_VALUE, 8'h00};
            3'd4:    w_rd_data = r_tcrit;
            3'd5:    w_rd_data = {r_thyst, 8'h00};
            3'd6:    w_rd_data = r_thigh;
            default: w_rd_data = r_tlow;
        endcase
    end

    // CS pipe resets low so a frame already in progress cannot arm the FSM.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            r_cs_pipe   <= 2'b00;
            r_sclk_pipe <= 2'b11;
            r_mosi_pipe <= 2'b00;
            r_sclk_prev <= 1'b1;
        end else begin
            r_cs_pipe   <= {r_cs_pipe[0], spi_cs_n};
            r_sclk_pipe <= {r_sclk_pipe[0], spi_sclk};
            r_mosi_pipe <= {r_mosi_pipe[0], spi_mosi};
            r_sclk_prev <= w_sclk_sync;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            r_state       <= S_IDLE;
            r_armed       <= 1'b0;
            r_bit_cnt     <= 4'd0;
            r_shift       <= 16'h0000;
            r_addr        <= 3'd0;
            r_cont        <= 1'b0;
            r_wide        <= 1'b0;
            r_word_seen   <= 1'b0;
            r_miso        <= 1'b1;
            r_miso_oe     <= 1'b0;
            r_reg_wr      <= 1'b0;
            r_reg_wr_addr <= 3'd0;
            r_busy        <= 1'b0;
            r_frame_err   <= 1'b0;
            r_rdy_n       <= 1'b1;
            r_cfg         <= CFG_RST;
            r_temp        <= 16'h0000;
            r_tcrit       <= TCRIT_RST;
            r_thyst       <= THYST_RST;
            r_thigh       <= THIGH_RST;
            r_tlow        <= TLOW_RST;
`ifdef ADT_SPI_RESET_EN
            r_ones        <= 5'd0;
`endif
        end else begin
            r_reg_wr    <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_cs_sync)
                r_armed <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (r_armed && !w_cs_sync) begin
                        r_state   <= S_CMD;
                        r_bit_cnt <= 4'd0;
                        r_busy    <= 1'b1;
                    end
                end
                S_CMD, S_RX, S_TX: begin
                    if (w_cs_sync) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_miso    <= 1'b1;
                        r_miso_oe <= 1'b0;
                        if (!(r_state == S_TX && w_cont_boundary))
                            r_frame_err <= 1'b1;
                    end else if (r_state == S_CMD) begin
                        if (w_rise) begin
                            r_shift <= w_rx_word;
                            if (r_bit_cnt == 4'd7) begin
                                r_bit_cnt   <= 4'd0;
                                r_addr      <= w_cmd_addr;
                                r_cont      <= r_shift[1];
                                r_wide      <= w_cmd_wide;
                                r_word_seen <= 1'b0;
                                if (r_shift[5]) begin
                                    r_state <= S_TX;
                                    r_shift <= w_rd_data;
                                end else begin
                                    r_state <= S_RX;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end else if (r_state == S_RX) begin
                        if (w_rise) begin
                            r_shift <= w_rx_word;
                            if (r_bit_cnt == w_last) begin
                                r_state <= S_DONE;
                                if (!w_addr_ro) begin
                                    r_reg_wr      <= 1'b1;
                                    r_reg_wr_addr <= r_addr;
                                    case (r_addr)
                                        3'd1:    r_cfg   <= w_rx_word[7:0];
                                        3'd4:    r_tcrit <= w_rx_word;
                                        3'd5:    r_thyst <= w_rx_word[7:0];
                                        3'd6:    r_thigh <= w_rx_word;
                                        3'd7:    r_tlow  <= w_rx_word;
                                        default: ;
                                    endcase
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end else begin
                        if (w_fall) begin
                            r_miso    <= r_shift[15];
                            r_miso_oe <= 1'b1;
                            r_shift   <= {r_shift[14:0], 1'b0};
                        end
                        if (w_rise) begin
                            if (r_bit_cnt == w_last) begin
                                r_bit_cnt   <= 4'd0;
                                r_word_seen <= 1'b1;
                                if (r_addr == 3'd2)
                                    r_rdy_n <= 1'b1;
                                if (r_cont && r_addr == 3'd2) begin
                                    r_shift <= r_temp;
                                end else begin
                                    r_state   <= S_DONE;
                                    r_miso    <= 1'b1;
                                    r_miso_oe <= 1'b0;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (w_cs_sync) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

`ifdef ADT_SPI_RESET_EN
            // Ones are counted across frame boundaries; the 32nd overrides
            // whatever the FSM did with that same edge.
            if (r_armed && !w_cs_sync && w_rise) begin
                if (!w_mosi) begin
                    r_ones <= 5'd0;
                end else if (r_ones == 5'd31) begin
                    r_ones    <= 5'd0;
                    r_state   <= S_DONE;
                    r_busy    <= 1'b1;
                    r_miso    <= 1'b1;
                    r_miso_oe <= 1'b0;
                    r_reg_wr  <= 1'b0;
                    r_rdy_n   <= 1'b1;
                    r_cfg     <= CFG_RST;
                    r_temp    <= 16'h0000;
                    r_tcrit   <= TCRIT_RST;
                    r_thyst   <= THYST_RST;
                    r_thigh   <= THIGH_RST;
                    r_tlow    <= TLOW_RST;
                end else begin
                    r_ones <= r_ones + 5'd1;
                end
            end
`endif

            // Host temperature update takes precedence over a read completion.
            if (temp_load) begin
                r_temp  <= temp_value;
                r_rdy_n <= 1'b0;
            end
        end
    end

    assign spi_miso    = r_miso;
    assign spi_miso_oe = r_miso_oe;
    assign cfg_reg     = r_cfg;
    assign reg_wr      = r_reg_wr;
    assign reg_wr_addr = r_reg_wr_addr;
    assign busy        = r_busy;
    assign frame_err   = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_adt_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_adt_spi_slave
// Brief    : Directed, table-driven bench for adt_spi_slave (SPI mode 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adt_spi_slave;

    logic        clk_sys;
    logic        rst_sys;
    logic        spi_cs_n;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [15:0] temp_value;
    logic        temp_load;
    logic [7:0]  cfg_reg;
    logic        reg_wr;
    logic [2:0]  reg_wr_addr;
    logic        busy;
    logic        frame_err;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int ferr_cnt = 0;
    logic [2:0] last_wr_addr = 3'd0;

    adt_spi_slave u_dut (
        .clk_sys     (clk_sys),
        .rst_sys     (rst_sys),
        .spi_cs_n    (spi_cs_n),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .temp_value  (temp_value),
        .temp_load   (temp_load),
        .cfg_reg     (cfg_reg),
        .reg_wr      (reg_wr),
        .reg_wr_addr (reg_wr_addr),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (reg_wr) begin
            wr_cnt++;
            last_wr_addr = reg_wr_addr;
        end
        if (frame_err)
            ferr_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // SCLK phases are 80 ns (8 clk_sys). MISO/OE sampled at the end of each low phase.
    task automatic clock_bits(input logic [63:0] bits, input int nbits,
                              output logic [63:0] miso_bits, output int oe_cnt);
        miso_bits = 64'd0;
        oe_cnt    = 0;
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_sclk = 1'b0;
            spi_mosi = bits[i];
            #79;
            miso_bits = {miso_bits[62:0], spi_miso};
            if (spi_miso_oe) oe_cnt++;
            #1;
            spi_sclk = 1'b1;
            #80;
        end
        spi_mosi = 1'b0;
    endtask

    task automatic spi_xfer(input logic [63:0] bits, input int nbits,
                            output logic [63:0] miso_bits, output int oe_cnt);
        spi_cs_n = 1'b0;
        #80;
        clock_bits(bits, nbits, miso_bits, oe_cnt);
        #80;
        spi_cs_n = 1'b1;
        #160;
    endtask

    task automatic pulse_temp(input logic [15:0] val);
        @(posedge clk_sys);
        #1;
        temp_value = val;
        temp_load  = 1'b1;
        @(posedge clk_sys);
        #1;
        temp_load  = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [63:0] mosi;
        int          nbits;
        int          dbits;
        logic [15:0] exp_data;
        int          exp_oe;
        int          exp_wr;
        logic [2:0]  exp_addr;
        int          exp_ferr;
        logic [7:0]  exp_cfg;
    } vec_t;

    vec_t vecs [12];

    localparam logic [15:0] C_THIGH_AFTER =
`ifdef ADT_SPI_RESET_EN
        16'h2000;
`else
        16'h1234;
`endif
    localparam logic [7:0] C_CFG_AFTER =
`ifdef ADT_SPI_RESET_EN
        8'h00;
`else
        8'h80;
`endif

    initial begin
        logic [63:0] mb;
        int          oe;
        int          wr0;
        int          fe0;
        logic [63:0] mask;

        vecs[0]  = '{"rd_id",      64'h5800,   16, 8,  16'h00C3, 8,  0, 3'd0, 0, 8'h00};
        vecs[1]  = '{"wr_cfg",     64'h0880,   16, 0,  16'h0000, 0,  1, 3'd1, 0, 8'h80};
        vecs[2]  = '{"rd_cfg",     64'h4800,   16, 8,  16'h0080, 8,  0, 3'd0, 0, 8'h80};
        vecs[3]  = '{"rd_status",  64'h4000,   16, 8,  16'h0080, 8,  0, 3'd0, 0, 8'h80};
        vecs[4]  = '{"rd_tcrit",   64'h600000, 24, 16, 16'h4980, 16, 0, 3'd0, 0, 8'h80};
        vecs[5]  = '{"rd_thyst",   64'h6800,   16, 8,  16'h0005, 8,  0, 3'd0, 0, 8'h80};
        vecs[6]  = '{"rd_tlow",    64'h780000, 24, 16, 16'h0500, 16, 0, 3'd0, 0, 8'h80};
        vecs[7]  = '{"abort5",     64'h0B,     5,  0,  16'h0000, 0,  0, 3'd0, 1, 8'h80};
        vecs[8]  = '{"rd_id2",     64'h5800,   16, 8,  16'h00C3, 8,  0, 3'd0, 0, 8'h80};
        vecs[9]  = '{"wr_ro_temp", 64'h10FFFF, 24, 0,  16'h0000, 0,  0, 3'd0, 0, 8'h80};
        vecs[10] = '{"rd_temp0",   64'h500000, 24, 16, 16'h0000, 16, 0, 3'd0, 0, 8'h80};
        vecs[11] = '{"wr_thigh",   64'h301234, 24, 0,  16'h0000, 0,  1, 3'd6, 0, 8'h80};

        rst_sys    = 1'b1;
        spi_cs_n   = 1'b1;
        spi_sclk   = 1'b1;
        spi_mosi   = 1'b0;
        temp_value = 16'h0000;
        temp_load  = 1'b0;
        repeat (4) @(posedge clk_sys);
        #1;
        rst_sys = 1'b0;
        #1;
        check("rst_miso", {63'd0, spi_miso}, 64'd1);
        check("rst_oe", {63'd0, spi_miso_oe}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_cfg", {56'd0, cfg_reg}, 64'h00);
        check("rst_wr", {63'd0, reg_wr}, 64'd0);
        check("rst_wr_addr", {61'd0, reg_wr_addr}, 64'd0);
        check("rst_ferr", {63'd0, frame_err}, 64'd0);
        #200;

        for (int v = 0; v < 12; v++) begin
            wr0 = wr_cnt;
            fe0 = ferr_cnt;
            spi_xfer(vecs[v].mosi, vecs[v].nbits, mb, oe);
            if (vecs[v].dbits > 0) begin
                mask = (64'd1 << vecs[v].dbits) - 64'd1;
                check({vecs[v].name, "_data"}, mb & mask, {48'd0, vecs[v].exp_data});
            end
            check({vecs[v].name, "_oe"}, oe, vecs[v].exp_oe);
            check({vecs[v].name, "_wr"}, wr_cnt - wr0, vecs[v].exp_wr);
            if (vecs[v].exp_wr > 0)
                check({vecs[v].name, "_wr_addr"}, {61'd0, last_wr_addr}, {61'd0, vecs[v].exp_addr});
            check({vecs[v].name, "_ferr"}, ferr_cnt - fe0, vecs[v].exp_ferr);
            check({vecs[v].name, "_cfg"}, {56'd0, cfg_reg}, {56'd0, vecs[v].exp_cfg});
        end

        spi_xfer(64'h700000, 24, mb, oe);
        check("rd_thigh", mb & 64'hFFFF, 64'h1234);

        // Temperature load clears RDY_n; a completed temp read sets it again.
        pulse_temp(16'h0C80);
        spi_xfer(64'h4000, 16, mb, oe);
        check("status_after_load", mb & 64'hFF, 64'h00);
        spi_xfer(64'h500000, 24, mb, oe);
        check("rd_temp", mb & 64'hFFFF, 64'h0C80);
        spi_xfer(64'h4000, 16, mb, oe);
        check("status_after_read", mb & 64'hFF, 64'h80);

        // Continuous temperature read with a mid-frame update.
        fe0 = ferr_cnt;
        fork
            spi_xfer(64'h0054_0000_0000_0000, 56, mb, oe);
            begin
                #5200;
                pulse_temp(16'h0D00);
            end
        join
        check("cont_word0", (mb >> 32) & 64'hFFFF, 64'h0C80);
        check("cont_word1", (mb >> 16) & 64'hFFFF, 64'h0C80);
        check("cont_word2", mb & 64'hFFFF, 64'h0D00);
        check("cont_oe", oe, 48);
        check("cont_ferr", ferr_cnt - fe0, 0);
        check("cont_busy_end", {63'd0, busy}, 64'd0);

        // Serial interface reset by 32 consecutive ones.
        spi_xfer(64'h0880, 16, mb, oe);
        check("pre_ones_cfg", {56'd0, cfg_reg}, 64'h80);
        fe0 = ferr_cnt;
        spi_xfer(64'hFFFF_FFFF, 32, mb, oe);
        check("ones_cfg", {56'd0, cfg_reg}, {56'd0, C_CFG_AFTER});
        check("ones_ferr", ferr_cnt - fe0, 0);
        spi_xfer(64'h700000, 24, mb, oe);
        check("ones_thigh", mb & 64'hFFFF, {48'd0, C_THIGH_AFTER});

        // Reset mid-frame: SPI ignored until CS seen high then low.
        spi_cs_n = 1'b0;
        #200;
        check("midframe_busy", {63'd0, busy}, 64'd1);
        @(negedge clk_sys);
        rst_sys = 1'b1;
        repeat (2) @(negedge clk_sys);
        rst_sys = 1'b0;
        #20;
        check("post_rst_busy", {63'd0, busy}, 64'd0);
        check("post_rst_cfg", {56'd0, cfg_reg}, 64'h00);
        wr0 = wr_cnt;
        clock_bits(64'h5800, 16, mb, oe);
        check("ignored_oe", oe, 0);
        check("ignored_busy", {63'd0, busy}, 64'd0);
        #80;
        spi_cs_n = 1'b1;
        #160;
        spi_xfer(64'h5800, 16, mb, oe);
        check("rearm_rd_id", mb & 64'hFF, 64'hC3);
        check("rearm_wr", wr_cnt - wr0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adt_spi_slave.md
Name: adt_spi_slave

Overview:
- SPI-mode-3 responder emulating the ADT7310 serial register interface: command byte, then 8/16-bit data.
- Sits in the AI channel self-test path, in place of the physical sensor, so the ADT7310 command sequencer can be exercised in loopback.
- Temperature comes from the host side; configuration writes are reported back to the host.

Parameters:
- ID_VALUE, 8'hC3, ID register (addr 3) contents.
- CFG_RST, 8'h00, config register (addr 1) reset value.
- TCRIT_RST, 16'h4980, T_crit register (addr 4) reset value.
- THYST_RST, 8'h05, T_hyst register (addr 5) reset value.
- THIGH_RST, 16'h2000, T_high register (addr 6) reset value.
- TLOW_RST, 16'h0500, T_low register (addr 7) reset value.

Ports:
- clk_sys  in  1  system clock; the only clock.
- rst_sys  in  1  synchronous reset, active high.
- spi_cs_n  in  1  chip select, active low, asynchronous.
- spi_sclk  in  1  SPI clock, CPOL=1, asynchronous.
- spi_mosi  in  1  serial data in.
- spi_miso  out  1  serial data out.
- spi_miso_oe  out  1  MISO drive enable.
- temp_value  in  16  new temperature word.
- temp_load  in  1  one-cycle strobe; loads temp_value.
- cfg_reg  out  8  current config register.
- reg_wr  out  1  one-cycle pulse per accepted register write.
- reg_wr_addr  out  3  address of that write.
- busy  out  1  high while a frame is active (synchronized CS low).
- frame_err  out  1  one-cycle pulse on an aborted frame.

Behaviour:
- Clock and reset: one clock, clk_sys; reset is synchronous and active-high (rst_sys).
- Input synchronizers: cs_n, sclk and mosi pass through 2-FF synchronizers. Edge detect works on the synchronized sclk.
  - Rise = sample MOSI. Fall = shift MISO.
  - Requirement: SCLK high and low phases each >= 4 clk_sys cycles.
- Reset values:
  - spi_miso=1, spi_miso_oe=0, reg_wr=0, reg_wr_addr=0, busy=0, frame_err=0.
  - cfg_reg=CFG_RST, temp=16'h0000.
  - status=8'h80 (bit7 RDY_n=1, other bits 0).
  - Remaining registers take their parameter defaults.
- Command byte, MSB first:
  - bit7 ignored; bit6 R/W (1=read); bits5:3 addr; bit2 C (continuous read); bits1:0 ignored.
- Register widths:
  - 8-bit: addr 0, 1, 3, 5.
  - 16-bit: addr 2, 4, 6, 7.
  - Read-only: addr 0, 2, 3. Writes to them shift in normally, but produce no update and no reg_wr.
- FSM states: IDLE, CMD, RX, TX, DONE.
  - IDLE: sync CS falls -> CMD, bit_cnt=0, busy=1.
  - CMD: 8 rising edges shift the command.
    - Read -> TX: shift register loaded with the selected register, left-aligned to width.
    - Write -> RX.
  - TX:
    - spi_miso_oe=1.
    - MSB is driven on the falling edge after the 8th command rise; each subsequent fall shifts the next bit.
    - After the last bit (8 or 16 rises):
      - C=1 and addr=2 -> reload the current temp and stay in TX.
      - Otherwise -> DONE.
      - A completed temp read sets status bit7 to 1.
  - RX: 8 or 16 rises. At the final rise, write the register and pulse reg_wr with reg_wr_addr for exactly 1 cycle, 1 clk_sys after the synchronized edge. Then -> DONE.
  - DONE: MISO tristated (oe=0, miso=1); further SCLK ignored until CS rises -> IDLE.
- CS rises in any state except IDLE/DONE:
  - Return to IDLE, no register update.
  - Pulse frame_err, except when CS rises in TX exactly on a word boundary with C=1 (normal end of a continuous read).
- busy = synchronized CS low, i.e. any state except IDLE.
- temp_load:
  - Updates temp and clears status bit7 the next cycle.
  - A word already loaded into the TX shift register is unaffected.
  - If temp_load and read completion fall in the same cycle, temp_load wins (bit7=0).
- rst_sys mid-frame: immediate return to reset values. The frame is not resumed; SPI activity is ignored until CS is next seen high, then low.

Optional Feature:
- Macro: ADT_SPI_RESET_EN.
- Defined: a counter counts consecutive MOSI=1 samples across frames while CS is low.
  - At 32, all registers return to reset defaults, the FSM goes to DONE, and frame_err does not pulse.
  - The counter clears on any 0 sample.
- Undefined: no counter; a run of ones is an ordinary command/data stream.

Test Plan:
- Reset, read cmd 0x58 (addr 3) -> MISO 8'hC3, oe high only for the 8 data bits, no reg_wr.
- Write cmd 0x08 + data 0x80 -> reg_wr pulse once, reg_wr_addr=1, cfg_reg=0x80. A read cmd 0x48 then returns 0x80.
- temp_load 0x0C80 -> status read (0x40) returns bit7=0. Read cmd 0x50 returns 0x0C80. A status re-read returns bit7=1.
- Cmd 0x54 (continuous temp), 48 data clocks, temp_load 0x0D00 mid-second word -> words 0x0C80, 0x0C80, 0x0D00; CS rise at a boundary gives no frame_err.
- CS rises after 5 command bits -> frame_err pulse, no register change, next frame decodes normally. Write cmd 0x10 (addr 2, RO) + 0xFFFF -> no reg_wr, temp unchanged.
- ADT_SPI_RESET_EN: write cfg 0x80, then 32 ones -> cfg_reg=0x00, T_high reads 0x2000. With the macro undefined, cfg_reg stays 0x80.
